// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers VGA timing from an active-low hs/vs pair on the
// pixel clock. Measures line and frame periods, declares lock after enough
// consistent frames, and regenerates the active-area enable with x/y.
module vga_sync_decoder #(
    parameter int HD          = 640,
    parameter int HB          = 48,
    parameter int VD          = 480,
    parameter int VB          = 31,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    output logic        en,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        locked,
    output logic [11:0] h_total,
    output logic [11:0] v_total
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [11:0] H_LO   = 12'(HB);
    localparam logic [11:0] H_HI   = 12'(HB + HD);
    localparam logic [11:0] V_LO   = 12'(VB);
    localparam logic [11:0] V_HI   = 12'(VB + VD);
    localparam logic [11:0] CMAX   = 12'hFFF;
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    // input synchronizer pairs
    logic hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
    logic vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;

    // free-running line/frame counters
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic        hs_seen_q, hs_seen_d;

    // lock tracking
    state_t      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic        frame_ok_q, frame_ok_d;
    logic        href_pend_q, href_pend_d;
    logic [11:0] h_ref_q, h_ref_d;
    logic [11:0] h_tot_q, h_tot_d;
    logic [11:0] v_tot_q, v_tot_d;

    // registered outputs
    logic        en_q, en_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;

    logic        hs_rise, vs_rise, timeout;
    logic [11:0] line_per;
    logic        line_bad, frame_good;
    logic        in_h, in_v;

    assign hs_rise  = hs_s1_q & ~hs_s2_q;
    assign vs_rise  = vs_s1_q & ~vs_s2_q;
    assign line_per = hcnt_q + 12'd1;
    // a line this long means hs has stopped toggling
    assign timeout  = (hcnt_q == CMAX);

    // edge detect inputs and advance the saturating position counters
    always_comb begin
        hs_s1_d = hs;
        hs_s2_d = hs_s1_q;
        vs_s1_d = vs;
        vs_s2_d = vs_s1_q;

        if (hs_rise)      hcnt_d = '0;
        else if (timeout) hcnt_d = hcnt_q;
        else              hcnt_d = hcnt_q + 12'd1;

        // frame restart takes priority over a coincident line count
        if (vs_rise)                        vcnt_d = '0;
        else if (hs_rise && vcnt_q != CMAX) vcnt_d = vcnt_q + 12'd1;
        else                                vcnt_d = vcnt_q;

        if (timeout)      hs_seen_d = 1'b0;
        else if (hs_rise) hs_seen_d = 1'b1;
        else              hs_seen_d = hs_seen_q;
    end

    // lock FSM: measure frames, compare against the stored reference
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        frame_ok_d  = frame_ok_q;
        href_pend_d = href_pend_q;
        h_ref_d     = h_ref_q;
        h_tot_d     = h_tot_q;
        v_tot_d     = v_tot_q;
        line_bad    = 1'b0;
        frame_good  = 1'b0;

        unique case (state_q)
            SEARCH: begin
                good_d = '0;
                if (vs_rise && hs_seen_q) begin
                    state_d     = MEASURE;
                    frame_ok_d  = 1'b1;
                    href_pend_d = 1'b1;
                end
            end
            MEASURE: begin
                if (hs_rise) begin
                    if (href_pend_q) begin
                        h_ref_d     = line_per;
                        href_pend_d = 1'b0;
                    end else if (line_per != h_ref_q) begin
                        line_bad   = 1'b1;
                        frame_ok_d = 1'b0;
                    end
                end
                if (vs_rise) begin
                    // first frame after a reset of good only has to be uniform
                    frame_good = frame_ok_q && !line_bad && !href_pend_q &&
                                 ((good_q == '0) ||
                                  (h_ref_q == h_tot_q && vcnt_q == v_tot_q));
                    // the latest frame always becomes the new reference
                    h_tot_d    = h_ref_q;
                    v_tot_d    = vcnt_q;
                    frame_ok_d = 1'b1;
                    if (frame_good) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_N) state_d = LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if ((hs_rise && line_per != h_tot_q) ||
                    (vs_rise && vcnt_q != v_tot_q))
                    state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase

        if (timeout) begin
            state_d = SEARCH;
            good_d  = '0;
        end

        // measured totals are only meaningful while locked
        if (state_q == LOCKED && state_d != LOCKED) begin
            h_tot_d = '0;
            v_tot_d = '0;
        end
    end

    // decode active area; uses next state so en drops on the unlock edge
    always_comb begin
        in_h = (hcnt_q >= H_LO) && (hcnt_q < H_HI);
        in_v = (vcnt_q >= V_LO) && (vcnt_q < V_HI);
        en_d = (state_d == LOCKED) && in_h && in_v;
        x_d  = '0;
        y_d  = '0;
        if (en_d) begin
            x_d = {4'd0, hcnt_q - H_LO};
            y_d = {4'd0, vcnt_q - V_LO};
        end
    end

    // state registers; sync flops idle high so reset sees no false edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_s1_q     <= 1'b1;
            hs_s2_q     <= 1'b1;
            vs_s1_q     <= 1'b1;
            vs_s2_q     <= 1'b1;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            hs_seen_q   <= 1'b0;
            state_q     <= SEARCH;
            good_q      <= '0;
            frame_ok_q  <= 1'b0;
            href_pend_q <= 1'b0;
            h_ref_q     <= '0;
            h_tot_q     <= '0;
            v_tot_q     <= '0;
            en_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            hs_s1_q     <= hs_s1_d;
            hs_s2_q     <= hs_s2_d;
            vs_s1_q     <= vs_s1_d;
            vs_s2_q     <= vs_s2_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            hs_seen_q   <= hs_seen_d;
            state_q     <= state_d;
            good_q      <= good_d;
            frame_ok_q  <= frame_ok_d;
            href_pend_q <= href_pend_d;
            h_ref_q     <= h_ref_d;
            h_tot_q     <= h_tot_d;
            v_tot_q     <= v_tot_d;
            en_q        <= en_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    assign en      = en_q;
    assign x       = x_q;
    assign y       = y_q;
    assign locked  = (state_q == LOCKED);
    assign h_total = h_tot_q;
    assign v_total = v_tot_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled source: 40-cycle lines (16 active,
// hs low for cycles 22..27, rise at 28 -> HB=12) and 30-line frames (12
// active, vs low on lines 20..21, rise at line 22 -> 8 hs rises to line 0).
module tb_vga_sync_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs  = 1'b1;
    logic        vs  = 1'b1;
    logic        en;
    logic [15:0] x, y;
    logic        locked;
    logic [11:0] h_total, v_total;

    vga_sync_decoder #(
        .HD(16), .HB(12), .VD(12), .VB(8), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs),
        .en(en), .x(x), .y(y), .locked(locked),
        .h_total(h_total), .v_total(v_total)
    );

    initial forever #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // generator position (next pixel to drive) and shape controls
    int px = 0, ln = 0, frame_vt = 30, long_ln = -1;
    bit sb_on = 1'b0, alt_on = 1'b0;
    int popped = 0;

    typedef struct {
        int unsigned cyc;
        int          x;
        int          y;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // drive one source pixel; active pixels in a scored frame are expected
    // as en/x/y three clk counts later (sample edge + 2)
    task automatic step();
        exp_t e;
        @(negedge clk);
        hs = !(px >= 22 && px < 28);
        vs = !(ln == 20 || ln == 21);
        if (sb_on && px < 16 && ln < 12) begin
            e.cyc = cyc + 3;
            e.x   = px;
            e.y   = ln;
            sbq.push_back(e);
        end
        px++;
        if (px == ((ln == long_ln) ? 41 : 40)) begin
            px = 0;
            ln++;
            if (ln == frame_vt) ln = 0;
        end
    endtask

    task automatic run_to(input int l, input int p);
        int n = 0;
        while (!(ln == l && px == p)) begin
            step();
            n++;
            if (n > 5000) begin
                n_err++;
                $display("FAIL run_to: position %0d,%0d not reached", l, p);
                $fatal(1, "generator stuck");
            end
        end
    endtask

    task automatic skip_vs(input int n);
        for (int i = 0; i < n; i++) begin
            run_to(22, 0);
            step();
        end
    endtask

    // the deciding vs rise is driven at k; locked must rise exactly at k+2
    task automatic relock_check(input string nm);
        run_to(22, 0);
        step();
        step();
        chk({nm, "_early"}, locked, 0);
        step();
        chk({nm, "_lock"}, locked, 1);
        chk({nm, "_htot"}, h_total, 40);
        chk({nm, "_vtot"}, v_total, 30);
    endtask

    // monitor: samples 1 time unit after each rising edge
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (en) chk("en_while_unlocked", locked, 1);
        if (alt_on) chk("alt_never_locked", locked, 0);
        if (sb_on) begin
            if (en) begin
                n_chk++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra: en at cyc %0d x %0d y %0d with nothing expected", cyc, x, y);
                end else begin
                    e = sbq.pop_front();
                    popped++;
                    if (e.cyc != cyc || x !== 16'(e.x) || y !== 16'(e.y)) begin
                        n_err++;
                        $display("FAIL sb_pix: got cyc %0d x %0d y %0d expected cyc %0d x %0d y %0d",
                                 cyc, x, y, e.cyc, e.x, e.y);
                    end
                end
            end else begin
                chk("idle_xy", {x, y}, 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_en", en, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_locked", locked, 0);
        chk("rst_htot", h_total, 0);
        chk("rst_vtot", v_total, 0);
        rst = 1'b0;

        // initial acquisition: lock on the third vs rise
        skip_vs(2);
        relock_check("acq");

        // one fully scored frame
        run_to(0, 0);
        sb_on = 1'b1;
        step();
        run_to(0, 0);
        sb_on = 1'b0;
        chk("sb_count", popped, 16 * 12);
        chk("sb_left", sbq.size(), 0);

        // line 5 stretched to 41 cycles; loss seen on line 6 hs rise
        long_ln = 5;
        run_to(6, 28);
        step();
        step();
        chk("corrupt_hold", locked, 1);
        step();
        chk("corrupt_drop", locked, 0);
        chk("corrupt_en", en, 0);
        chk("corrupt_htot", h_total, 0);
        chk("corrupt_vtot", v_total, 0);
        long_ln = -1;
        skip_vs(2);
        relock_check("relock1");

        // asynchronous reset mid-line while locked; pixel (6,5) is on en now
        run_to(5, 10);
        chk("pre_rst_en", en, 1);
        chk("pre_rst_x", x, 6);
        chk("pre_rst_y", y, 5);
        rst = 1'b1;
        #1;
        chk("arst_en", en, 0);
        chk("arst_x", x, 0);
        chk("arst_y", y, 0);
        chk("arst_locked", locked, 0);
        chk("arst_htot", h_total, 0);
        chk("arst_vtot", v_total, 0);
        step();
        step();
        step();
        rst = 1'b0;
        skip_vs(2);
        relock_check("relock2");

        // hold hs/vs high from the start of the next frame. Last hs rise is
        // 12 drives before hold step 0, so hcnt hits 4095 at hold step 4085
        // and the timeout takes effect one edge later.
        run_to(0, 0);
        for (int i = 0; i < 4200; i++) begin
            @(negedge clk);
            hs = 1'b1;
            vs = 1'b1;
            if (i == 4085) chk("hold_locked", locked, 1);
            if (i == 4086) begin
                chk("timeout_locked", locked, 0);
                chk("timeout_htot", h_total, 0);
            end
        end
        chk("hold_en", en, 0);
        chk("hold_x", x, 0);
        chk("hold_y", y, 0);
        chk("hold_locked_end", locked, 0);
        chk("hold_vtot", v_total, 0);
        skip_vs(2);
        relock_check("relock3");

        // frames alternating 31 and 30 lines must never lock
        for (int i = 0; i < 6; i++) begin
            frame_vt = (i % 2 == 0) ? 31 : 30;
            run_to(0, 0);
            run_to(22, 0);
            step();
            step();
            step();
            chk("alt_locked", locked, 0);
            if (i == 0) alt_on = 1'b1;
        end
        alt_on   = 1'b0;
        frame_vt = 30;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
